// File: rtl/branch_ctrl_pkg.sv
// Shared constants for the ID-stage branch controller: MIPS branch
// opcodes, REGIMM branch sub-ops and the controller state encoding.
package branch_ctrl_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {
        BR_IDLE  = 2'b00,
        BR_WAIT  = 2'b01,
        BR_REDIR = 2'b10
    } br_state_t;

endpackage

// File: rtl/branch_ctrl_decode.sv
// Combinational branch classifier: flags branch opcodes and whether
// the compare needs rt as well as rs.
module branch_decode
    import branch_ctrl_pkg::*;
(
    input  logic [5:0] id_op,
    input  logic [4:0] id_rt,
    output logic       is_branch,
    output logic       uses_rt
);

    // Classify the ID opcode; unknown REGIMM sub-ops are not branches
    always_comb begin
        is_branch = 1'b0;
        uses_rt   = 1'b0;
        case (id_op)
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                is_branch = 1'b1;
            end
            OP_REGIMM: begin
                is_branch = (id_rt == RT_BLTZ)   ||
                            (id_rt == RT_BGEZ)   ||
                            (id_rt == RT_BLTZAL) ||
                            (id_rt == RT_BGEZAL);
            end
            default: begin
                is_branch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: operand-hazard stall, taken latch and
// held PC redirect. Statistics counters exist when BRANCH_STATS_EN is defined.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [5:0]    id_op,
    input  logic [4:0]    id_rt,
    input  logic [AW-1:0] id_target,
    input  logic          cmp_taken,
    input  logic          rs_hazard,
    input  logic          rt_hazard,
    input  logic          if_ready,
    input  logic          flush,
    output logic          id_stall,
    output logic          pc_redirect,
    output logic [AW-1:0] pc_target,
    output logic          br_busy,
    output logic [31:0]   branch_cnt,
    output logic [31:0]   taken_cnt,
    output logic [31:0]   stall_cnt
);

    br_state_t state;

    logic is_branch;
    logic uses_rt;
    logic hazard;
    logic br;
    logic kill;
    logic stall_raw;
    logic resolve_raw;
    logic resolve;
    logic taken;

    branch_decode u_decode (
        .id_op     (id_op),
        .id_rt     (id_rt),
        .is_branch (is_branch),
        .uses_rt   (uses_rt)
    );

    assign hazard = rs_hazard | (uses_rt & rt_hazard);
    assign br     = id_valid & is_branch;
    assign kill   = flush | rst;

    // Stall/resolve qualification; branches in the delay slot are ignored
    always_comb begin
        stall_raw   = 1'b0;
        resolve_raw = 1'b0;
        case (state)
            BR_IDLE, BR_WAIT: begin
                stall_raw   = br & hazard;
                resolve_raw = br & ~hazard;
            end
            default: begin
                stall_raw   = 1'b0;
                resolve_raw = 1'b0;
            end
        endcase
    end

    assign resolve     = resolve_raw & ~kill;
    assign taken       = resolve & cmp_taken;
    assign id_stall    = stall_raw & ~kill;
    assign pc_redirect = (state == BR_REDIR) & ~kill;
    assign br_busy     = (state != BR_IDLE);

    // Controller FSM and target latch; flush drops any pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BR_IDLE;
            pc_target <= '0;
        end else if (flush) begin
            state <= BR_IDLE;
        end else begin
            case (state)
                BR_IDLE: begin
                    if (br && hazard) begin
                        state <= BR_WAIT;
                    end else if (taken) begin
                        state     <= BR_REDIR;
                        pc_target <= id_target;
                    end
                end
                BR_WAIT: begin
                    if (!br) begin
                        state <= BR_IDLE;
                    end else if (!hazard) begin
                        if (taken) begin
                            state     <= BR_REDIR;
                            pc_target <= id_target;
                        end else begin
                            state <= BR_IDLE;
                        end
                    end
                end
                BR_REDIR: begin
                    if (if_ready) begin
                        state <= BR_IDLE;
                    end
                end
                default: begin
                    state <= BR_IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_q;
    logic [31:0] taken_q;
    logic [31:0] stall_q;

    // Free-running statistics, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_q <= '0;
            taken_q  <= '0;
            stall_q  <= '0;
        end else begin
            if (resolve)  branch_q <= branch_q + 32'd1;
            if (taken)    taken_q  <= taken_q + 32'd1;
            if (id_stall) stall_q  <= stall_q + 32'd1;
        end
    end

    assign branch_cnt = branch_q;
    assign taken_cnt  = taken_q;
    assign stall_cnt  = stall_q;
`else
    assign branch_cnt = 32'd0;
    assign taken_cnt  = 32'd0;
    assign stall_cnt  = 32'd0;
`endif

endmodule
